// File: rtl/mux_pkg.sv
// Shared constants and helpers for the stream multiplexer.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Index width that never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int inputs = 4,
    localparam int IW     = idx_w(inputs)
) (
    input  logic [inputs-1:0] req,
    input  logic [IW-1:0]     ptr,
    output logic [IW-1:0]     grant_idx,
    output logic              grant_valid
);

    logic [IW-1:0] idx;

    // Walk from farthest to nearest so the nearest requester wins the last write.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = '0;
        for (int k = inputs - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr) + k) % inputs);
            if (req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/mux_stream_nbit.sv
// N-input registered stream multiplexer with fixed or round-robin selection
// and a single output register stage.
module mux_stream_nbit
    import mux_pkg::*;
#(
    parameter  int inputs = 4,
    parameter  int width  = 8,
    localparam int IW     = idx_w(inputs)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [inputs*width-1:0]   w_in,
    input  logic [inputs-1:0]         v_in,
    output logic [inputs-1:0]         r_out,
    input  logic                      mode_in,
    input  logic [IW-1:0]             s_in,
    output logic [width-1:0]          f_out,
    output logic                      v_out,
    input  logic                      r_in,
    output logic [IW-1:0]             ch_out
);

    logic [width-1:0] f_q, f_d;
    logic             v_q, v_d;
    logic [IW-1:0]    ch_q, ch_d;
    logic [IW-1:0]    ptr_q, ptr_d;

    logic             load_en;
    logic             fx_valid, rr_valid, gnt_valid;
    logic [IW-1:0]    rr_idx, gnt_idx;

    rr_arbiter #(.inputs(inputs)) u_arb (
        .req         (v_in),
        .ptr         (ptr_q),
        .grant_idx   (rr_idx),
        .grant_valid (rr_valid)
    );

    // Out-of-range fixed selects (non-power-of-2 inputs) never grant.
    assign fx_valid = (int'(s_in) < inputs) && v_in[s_in];

    always_comb begin
        load_en   = !v_q || r_in;
        gnt_valid = (mode_in == MODE_RR) ? rr_valid : fx_valid;
        gnt_idx   = (mode_in == MODE_RR) ? rr_idx   : s_in;

        r_out = '0;
        if (!reset && load_en && gnt_valid)
            r_out[gnt_idx] = 1'b1;

        f_d   = f_q;
        v_d   = v_q;
        ch_d  = ch_q;
        ptr_d = ptr_q;
        if (load_en) begin
            v_d = gnt_valid;
            if (gnt_valid) begin
                f_d  = w_in[int'(gnt_idx)*width +: width];
                ch_d = gnt_idx;
                if (mode_in == MODE_RR)
                    ptr_d = (int'(gnt_idx) == inputs - 1) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            f_q   <= '0;
            v_q   <= 1'b0;
            ch_q  <= '0;
            ptr_q <= '0;
        end else begin
            f_q   <= f_d;
            v_q   <= v_d;
            ch_q  <= ch_d;
            ptr_q <= ptr_d;
        end
    end

    assign f_out  = f_q;
    assign v_out  = v_q;
    assign ch_out = ch_q;

endmodule

// File: tb/tb_mux_stream_nbit.sv
// Directed bench for mux_stream_nbit (4 x 8-bit) with a per-cycle reference model.
module tb_mux_stream_nbit;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [N*W-1:0] w_in;
    logic [N-1:0]   v_in;
    logic [N-1:0]   r_out;
    logic           mode_in;
    logic [1:0]     s_in;
    logic [W-1:0]   f_out;
    logic           v_out;
    logic           r_in;
    logic [1:0]     ch_out;

    int errors = 0;
    int checks = 0;

    mux_stream_nbit #(.inputs(N), .width(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .w_in    (w_in),
        .v_in    (v_in),
        .r_out   (r_out),
        .mode_in (mode_in),
        .s_in    (s_in),
        .f_out   (f_out),
        .v_out   (v_out),
        .r_in    (r_in),
        .ch_out  (ch_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Inputs change just after the rising edge; everything is observed on the falling edge.
    task automatic step(input logic rst, input logic md, input logic [1:0] s,
                        input logic [3:0] v, input logic rin);
        @(posedge clk);
        #1;
        reset = rst; mode_in = md; s_in = s; v_in = v; r_in = rin;
    endtask

    // Reference model: the observable state after each rising edge.
    int m_v = 0, m_f = 0, m_ch = 0, m_ptr = 0;

    initial begin
        @(posedge clk);
        forever begin
            int g, gv, le, exp_r;
            @(negedge clk);
            le = (m_v == 0 || r_in) ? 1 : 0;
            gv = 0; g = 0;
            if (mode_in) begin
                for (int k = 0; k < N; k++)
                    if (!gv && v_in[(m_ptr + k) % N]) begin gv = 1; g = (m_ptr + k) % N; end
            end else if (v_in[s_in]) begin
                gv = 1; g = int'(s_in);
            end
            exp_r = (!reset && le && gv) ? (1 << g) : 0;
            chk("model r_out", 32'(r_out), 32'(exp_r));
            chk("model v_out", 32'(v_out), 32'(m_v));
            chk("model f_out", 32'(f_out), 32'(m_f));
            chk("model ch_out", 32'(ch_out), 32'(m_ch));
            if (reset) begin
                m_v = 0; m_f = 0; m_ch = 0; m_ptr = 0;
            end else if (le) begin
                m_v = gv;
                if (gv) begin
                    m_f  = int'(w_in[g*W +: W]);
                    m_ch = g;
                    if (mode_in) m_ptr = (g + 1) % N;
                end
            end
        end
    end

    initial begin
        reset = 1'b1; mode_in = 1'b0; s_in = 2'd0; v_in = 4'b1111; r_in = 1'b1;
        w_in = {8'h44, 8'h33, 8'h22, 8'h11};

        // Reset
        step(1, 0, 0, 4'b1111, 1);
        step(1, 0, 0, 4'b1111, 1);
        @(negedge clk);
        chk("rst v_out", 32'(v_out), 0);
        chk("rst f_out", 32'(f_out), 0);
        chk("rst ch_out", 32'(ch_out), 0);
        chk("rst r_out", 32'(r_out), 0);

        // Fixed select
        w_in[2*W +: W] = 8'hA5;
        step(0, 0, 2, 4'b0100, 1);
        @(negedge clk);
        chk("fix r_out", 32'(r_out), 32'b0100);
        step(0, 0, 2, 4'b0011, 1);
        @(negedge clk);
        chk("fix f_out", 32'(f_out), 32'hA5);
        chk("fix v_out", 32'(v_out), 1);
        chk("fix ch_out", 32'(ch_out), 2);
        chk("fix nogrant r_out", 32'(r_out), 0);
        step(0, 0, 2, 4'b0011, 1);
        @(negedge clk);
        chk("fix drain v_out", 32'(v_out), 0);
        chk("fix hold f_out", 32'(f_out), 32'hA5);

        // Backpressure
        step(0, 0, 2, 4'b1111, 1);
        step(0, 0, 2, 4'b1111, 0);
        w_in[2*W +: W] = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 2, 4'b1111, 0);
            @(negedge clk);
            chk("bp f_out", 32'(f_out), 32'hA5);
            chk("bp ch_out", 32'(ch_out), 2);
            chk("bp r_out", 32'(r_out), 0);
        end
        step(0, 0, 2, 4'b1111, 1);
        @(negedge clk);
        chk("bp release r_out", 32'(r_out), 32'b0100);
        step(0, 0, 2, 4'b1111, 0);
        step(0, 0, 2, 4'b1111, 0);
        @(negedge clk);
        chk("bp one f_out", 32'(f_out), 32'h5A);
        chk("bp one v_out", 32'(v_out), 1);

        // Round-robin, all valid
        w_in = {8'd13, 8'd12, 8'd11, 8'd10};
        step(0, 1, 0, 4'b1111, 1);
        for (int j = 1; j <= 4; j++) begin
            step(0, 1, 0, 4'b1111, 1);
            @(negedge clk);
            chk("rr ch_out", 32'(ch_out), 32'(j - 1));
            chk("rr f_out", 32'(f_out), 32'(10 + j - 1));
        end

        // Round-robin, sparse
        step(0, 1, 0, 4'b1010, 1);
        @(negedge clk);
        chk("rr wrap ch_out", 32'(ch_out), 0);
        chk("rr wrap f_out", 32'(f_out), 10);
        for (int k = 1; k <= 4; k++) begin
            step(0, 1, 0, 4'b1010, 1);
            @(negedge clk);
            chk("sparse ch_out", 32'(ch_out), (k % 2 == 1) ? 32'd1 : 32'd3);
        end

        // Fixed after round-robin
        step(0, 0, 0, 4'b1011, 1);
        for (int m = 1; m <= 3; m++) begin
            step(0, 0, 0, 4'b1011, 1);
            @(negedge clk);
            chk("fix0 ch_out", 32'(ch_out), 0);
            chk("fix0 f_out", 32'(f_out), 10);
        end

        // Reset while holding data
        step(0, 0, 0, 4'b1011, 0);
        @(negedge clk);
        chk("midrst pre v_out", 32'(v_out), 1);
        step(1, 0, 0, 4'b1011, 0);
        @(negedge clk);
        chk("midrst r_out", 32'(r_out), 0);
        step(0, 1, 0, 4'b1111, 1);
        @(negedge clk);
        chk("midrst v_out", 32'(v_out), 0);
        step(0, 1, 0, 4'b1111, 1);
        @(negedge clk);
        chk("midrst first ch_out", 32'(ch_out), 0);
        chk("midrst first v_out", 32'(v_out), 1);
        step(0, 1, 0, 4'b1111, 1);
        @(negedge clk);
        chk("midrst second ch_out", 32'(ch_out), 1);

        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
